video2ram: RTL and testbench
============================

# video2ram

Pixel-to-line-buffer writer between the input capture stage and the HDMI output stage. It takes the registered RGB pixel stream and the visible-area `counterX`/`counterY` from the capture stage, and writes each new pixel once into a ring of line slots in a dual-port RAM. It raises `starttrigger` once enough lines are buffered so the HDMI side can begin reading, and it re-arms on `resync`.

## Interface
- `LINE_WIDTH`, 720: pixels per line slot.
- `LINES`, 4: number of line slots in the ring (power of two).
- `LINE_HEIGHT`, 600: maximum visible lines per frame; lines at or beyond this are not written.
- `ADDR_W`, 12: RAM address width. `LINES*LINE_WIDTH` must be ≤ 2^ADDR_W.
- `START_LINES`, 2: number of committed lines required before `starttrigger` asserts.
- `clock` in 1: capture pixel clock (54 MHz domain). Single clock.
- `reset_n` in 1: asynchronous, active-low reset.
- `red`, `green`, `blue` in 8 each: pixel data from the capture stage.
- `counterX` in 12: visible-area X.
- `counterY` in 12: visible-area Y.
- `resync` in 1: high means output timing is not aligned. Clears and re-arms the trigger.
- `read_slot` in log2(LINES): slot currently read by the HDMI side. Used only when `VIDEO2RAM_OVERRUN_DETECT_EN` is defined.
- `wraddr` out ADDR_W: RAM write address.
- `wrdata` out 24: `{red, green, blue}`.
- `wren` out 1: RAM write enable, one cycle per pixel.
- `write_slot` out log2(LINES): slot currently being written.
- `starttrigger` out 1: level; buffer primed.
- `overrun` out 1: sticky; a write entered the slot being read.

## Operation
- **Input register stage.** `x_q`, `y_q` and `rgb_q` register the inputs every cycle.
- **New-pixel detect.** `px_new = (counterX != x_q)`.
  - The capture stage advances X every second clock, so a new pixel occurs at most every 2 cycles.
- **New-line detect.** `ln_new = (counterY != y_q)`.
- **State machine.** `WAIT_FRAME` → `ACTIVE` → `FRAME_DONE`.
  - `WAIT_FRAME` (reset state): on `ln_new && counterY==0`, clear the slot base, `write_slot` and `line_cnt`, then go to `ACTIVE`.
  - `ACTIVE`, pixel write: on `px_new && counterX < LINE_WIDTH && counterY < LINE_HEIGHT`, issue a write with `wraddr = base + counterX` and `wrdata = {red, green, blue}`.
  - `ACTIVE`, line commit: on `ln_new`, commit the line.
    - `line_cnt` increments.
    - `base += LINE_WIDTH`.
    - `write_slot` increments.
    - When `write_slot` wraps from LINES-1 to 0, `base` returns to 0. No multiplier is used.
  - `ACTIVE` exit: when `line_cnt` reaches LINE_HEIGHT, go to `FRAME_DONE`.
  - `FRAME_DONE`: no writes. On `ln_new && counterY==0`, perform the same re-initialisation as in `WAIT_FRAME` and enter `ACTIVE`.
- **Frame start in `ACTIVE`.** `counterY` returning to 0 while in `ACTIVE` is a short frame. It is treated as a frame start (re-init) and is not a line commit.
- **Trigger.**
  - Sets when `line_cnt == START_LINES` is committed and `resync == 0`.
  - Holds until `resync == 1`, which clears it and returns the FSM to `WAIT_FRAME`.
  - With `resync` held high, the FSM keeps writing lines but the trigger stays 0.
- **Simultaneous events.** A pixel and a line commit in the same cycle: the write uses the old `base`, and the commit takes effect next cycle.
- **Mid-operation reset.** `reset_n` low forces all state and outputs to reset values immediately. Writing resumes at the next frame start.

## Timing
- Latency is 1 cycle: inputs sampled at cycle n (`px_new` true) give `wren`, `wraddr` and `wrdata` valid at n+1.
- `wren` is a single-cycle pulse per pixel. Back-to-back pulses never occur under a 2-cycle pixel cadence.
- `write_slot` and `starttrigger` update 1 cycle after the `ln_new` cycle.
- Reset values: `wraddr` 0, `wrdata` 0, `wren` 0, `write_slot` 0, `starttrigger` 0, `overrun` 0.
- Arithmetic: `base + counterX` is computed in ADDR_W bits. `counterX` is truncated to ADDR_W, which is safe because the address is bounded by `LINES*LINE_WIDTH`.

## Configuration
- `VIDEO2RAM_OVERRUN_DETECT_EN` defined:
  - On a line commit, if the next `write_slot` equals `read_slot` while `starttrigger == 1`, `overrun` sets.
  - `overrun` is sticky until `resync == 1` or reset.
- Undefined:
  - `overrun` is tied to 0.
  - `read_slot` is ignored and produces no logic.

## Structure
- Shared package `video2ram_pkg`:
  - FSM state enum (`WAIT_FRAME`, `ACTIVE`, `FRAME_DONE`).
  - Default constants: `LINE_WIDTH` 720, `LINES` 4, `START_LINES` 2.
  - `SLOT_W = $clog2(LINES)`.
- One sub-module, `video2ram_slot_ctrl`: holds `base`, `write_slot` and `line_cnt` and performs the wrap logic. The top level keeps the input registers, edge detection, write port, trigger and overrun logic.

## Test plan
- **Reset.** `reset_n` low mid-frame → all outputs 0 the next cycle. After release, no `wren` until `counterY` returns to 0.
- **Addressing.** Frame with X 0..719 every 2 cycles for 3 lines → 720 `wren` pulses per line; line 2 addresses are 1440..2159; `wrdata` matches the inputs 1 cycle later.
- **Ring wrap.** 5 lines → `write_slot` sequence 0,1,2,3,0. Line 4 addresses restart at 0..719.
- **Trigger.** `resync=0`, 2 lines committed → `starttrigger` = 1 one cycle after the second `ln_new`. Then `resync=1` for 1 cycle → trigger 0 and FSM in `WAIT_FRAME`.
- **Bounds.** `counterX=720..1000` and `counterY=LINE_HEIGHT` → no `wren`.
- **Overrun (macro on).** `read_slot=2`, trigger high, commit line into slot 1 → `overrun`=1, held through subsequent lines until `resync`. With the macro off, `overrun` stays 0.

Source files
------------

// File: rtl/video2ram_pkg.sv
// video2ram shared definitions: FSM state encoding and default geometry.
// Optional feature macro used by the top level: VIDEO2RAM_OVERRUN_DETECT_EN.
package video2ram_pkg;

    // Frame tracking states of the line-buffer writer
    typedef enum logic [1:0] {
        WAIT_FRAME = 2'd0,
        ACTIVE     = 2'd1,
        FRAME_DONE = 2'd2
    } state_t;

    // Default geometry; the top level exposes these as overridable parameters
    localparam int DEF_LINE_WIDTH  = 720;
    localparam int DEF_LINES       = 4;
    localparam int DEF_START_LINES = 2;
    localparam int DEF_LINE_HEIGHT = 600;
    localparam int DEF_ADDR_W      = 12;
    localparam int SLOT_W          = $clog2(DEF_LINES);

endpackage

// File: rtl/video2ram_slot_ctrl.sv
// video2ram slot controller: tracks the line slot being written, its base
// address in the RAM and the number of lines committed in the current frame.
// The base advances by LINE_WIDTH per commit and returns to 0 when the slot
// index wraps, so no multiplier is needed.
module video2ram_slot_ctrl
    import video2ram_pkg::*;
#(
    parameter int LINE_WIDTH = DEF_LINE_WIDTH,
    parameter int LINES      = DEF_LINES,
    parameter int ADDR_W     = DEF_ADDR_W,
    parameter int CNT_W      = 10
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic                     init,
    input  logic                     commit,
    output logic [ADDR_W-1:0]        base,
    output logic [$clog2(LINES)-1:0] write_slot,
    output logic [$clog2(LINES)-1:0] next_slot,
    output logic [CNT_W-1:0]         line_cnt
);

    localparam int SW = $clog2(LINES);

    logic [ADDR_W-1:0] base_q, base_d;
    logic [SW-1:0]     slot_q, slot_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    // Frame start clears the ring position; a commit steps to the next slot
    always_comb begin
        base_d = base_q;
        slot_d = slot_q;
        cnt_d  = cnt_q;
        if (init) begin
            base_d = '0;
            slot_d = '0;
            cnt_d  = '0;
        end else if (commit) begin
            cnt_d  = cnt_q + CNT_W'(1);
            slot_d = slot_q + SW'(1);
            if (slot_q == SW'(LINES - 1)) begin
                base_d = '0;
            end else begin
                base_d = base_q + ADDR_W'(LINE_WIDTH);
            end
        end
    end

    // Ring position registers
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            base_q <= '0;
            slot_q <= '0;
            cnt_q  <= '0;
        end else begin
            base_q <= base_d;
            slot_q <= slot_d;
            cnt_q  <= cnt_d;
        end
    end

    assign base       = base_q;
    assign write_slot = slot_q;
    assign next_slot  = slot_q + SW'(1);
    assign line_cnt   = cnt_q;

endmodule

// File: rtl/video2ram.sv
// video2ram: writes each new captured pixel once into a ring of line slots in
// a dual-port RAM and raises starttrigger once enough lines are buffered.
// Optional feature: define VIDEO2RAM_OVERRUN_DETECT_EN to flag a commit into
// the slot the HDMI side is reading; otherwise overrun is tied low.
module video2ram
    import video2ram_pkg::*;
#(
    parameter int LINE_WIDTH  = DEF_LINE_WIDTH,
    parameter int LINES       = DEF_LINES,
    parameter int LINE_HEIGHT = DEF_LINE_HEIGHT,
    parameter int ADDR_W      = DEF_ADDR_W,
    parameter int START_LINES = DEF_START_LINES
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic [7:0]               red,
    input  logic [7:0]               green,
    input  logic [7:0]               blue,
    input  logic [11:0]              counterX,
    input  logic [11:0]              counterY,
    input  logic                     resync,
    input  logic [$clog2(LINES)-1:0] read_slot,
    output logic [ADDR_W-1:0]        wraddr,
    output logic [23:0]              wrdata,
    output logic                     wren,
    output logic [$clog2(LINES)-1:0] write_slot,
    output logic                     starttrigger,
    output logic                     overrun
);

    localparam int          SW    = $clog2(LINES);
    localparam int          CNT_W = $clog2(LINE_HEIGHT + 1);
    localparam logic [11:0] X_LIM = 12'(LINE_WIDTH);
    localparam logic [11:0] Y_LIM = 12'(LINE_HEIGHT);

    logic [11:0]       x_q, y_q;
    logic [23:0]       rgb_q;
    state_t            state_q, state_d;
    logic              wren_q, wren_d;
    logic [ADDR_W-1:0] wraddr_q, wraddr_d;
    logic              trig_q, trig_d;

    logic              px_new, ln_new, frame_start;
    logic              init, commit;
    logic [ADDR_W-1:0] base;
    logic [SW-1:0]     next_slot;
    logic [CNT_W-1:0]  line_cnt;

    assign px_new      = (counterX != x_q);
    assign ln_new      = (counterY != y_q);
    assign frame_start = ln_new && (counterY == 12'd0);

    video2ram_slot_ctrl #(
        .LINE_WIDTH (LINE_WIDTH),
        .LINES      (LINES),
        .ADDR_W     (ADDR_W),
        .CNT_W      (CNT_W)
    ) u_slot_ctrl (
        .clock      (clock),
        .reset_n    (reset_n),
        .init       (init),
        .commit     (commit),
        .base       (base),
        .write_slot (write_slot),
        .next_slot  (next_slot),
        .line_cnt   (line_cnt)
    );

    // Frame FSM, pixel write request and trigger next-state
    always_comb begin
        state_d  = state_q;
        init     = 1'b0;
        commit   = 1'b0;
        wren_d   = 1'b0;
        wraddr_d = wraddr_q;
        trig_d   = resync ? 1'b0 : trig_q;
        unique case (state_q)
            WAIT_FRAME, FRAME_DONE: begin
                if (frame_start) begin
                    init    = 1'b1;
                    state_d = ACTIVE;
                end
            end
            ACTIVE: begin
                // The write uses the current base even if a commit happens now
                if (px_new && (counterX < X_LIM) && (counterY < Y_LIM)) begin
                    wren_d   = 1'b1;
                    wraddr_d = base + ADDR_W'(counterX);
                end
                if (frame_start) begin
                    init = 1'b1;
                end else if (line_cnt >= CNT_W'(LINE_HEIGHT)) begin
                    state_d = FRAME_DONE;
                end else if (ln_new) begin
                    commit = 1'b1;
                    if ((line_cnt == CNT_W'(START_LINES - 1)) && !resync) begin
                        trig_d = 1'b1;
                    end
                end
            end
            default: state_d = WAIT_FRAME;
        endcase
        // Resync only re-arms a primed buffer; with resync held from the start
        // the trigger never sets, so line writing carries on undisturbed.
        if (resync && trig_q) begin
            state_d = WAIT_FRAME;
            init    = 1'b0;
            commit  = 1'b0;
        end
    end

    // Input capture, FSM state, write port and trigger registers
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            x_q      <= '0;
            y_q      <= '0;
            rgb_q    <= '0;
            state_q  <= WAIT_FRAME;
            wren_q   <= 1'b0;
            wraddr_q <= '0;
            trig_q   <= 1'b0;
        end else begin
            x_q      <= counterX;
            y_q      <= counterY;
            rgb_q    <= {red, green, blue};
            state_q  <= state_d;
            wren_q   <= wren_d;
            wraddr_q <= wraddr_d;
            trig_q   <= trig_d;
        end
    end

    assign wraddr       = wraddr_q;
    assign wrdata       = rgb_q;
    assign wren         = wren_q;
    assign starttrigger = trig_q;

`ifdef VIDEO2RAM_OVERRUN_DETECT_EN
    logic ovr_q, ovr_d;

    // Sticky overrun: a commit would move writing into the slot being read
    always_comb begin
        ovr_d = ovr_q;
        if (resync) begin
            ovr_d = 1'b0;
        end else if (commit && (next_slot == read_slot) && trig_q) begin
            ovr_d = 1'b1;
        end
    end

    // Overrun flag register
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            ovr_q <= 1'b0;
        end else begin
            ovr_q <= ovr_d;
        end
    end

    assign overrun = ovr_q;
`else
    logic unused_slot_bits;
    assign unused_slot_bits = ^{read_slot, next_slot};
    assign overrun          = 1'b0;
`endif

endmodule

// File: tb/tb_video2ram.sv
// Self-checking bench for video2ram: randomized pixel/line stimulus compared
// cycle by cycle against a frame-level reference model (slot = line index mod
// LINES, address = slot * LINE_WIDTH + x).
module tb_video2ram;

    localparam int LW = 720;
    localparam int NL = 4;
    localparam int LH = 600;
    localparam int SL = 2;
    localparam int HB = 1023;   // horizontal blanking X marker
    localparam int VB = 700;    // vertical blanking Y marker
`ifdef VIDEO2RAM_OVERRUN_DETECT_EN
    localparam bit OVR_EN = 1'b1;
`else
    localparam bit OVR_EN = 1'b0;
`endif

    logic        clock = 1'b0;
    logic        reset_n;
    logic [7:0]  red, green, blue;
    logic [11:0] counterX, counterY;
    logic        resync;
    logic [1:0]  read_slot;
    logic [11:0] wraddr;
    logic [23:0] wrdata;
    logic        wren;
    logic [1:0]  write_slot;
    logic        starttrigger;
    logic        overrun;

    always #5 clock = ~clock;

    video2ram dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .red          (red),
        .green        (green),
        .blue         (blue),
        .counterX     (counterX),
        .counterY     (counterY),
        .resync       (resync),
        .read_slot    (read_slot),
        .wraddr       (wraddr),
        .wrdata       (wrdata),
        .wren         (wren),
        .write_slot   (write_slot),
        .starttrigger (starttrigger),
        .overrun      (overrun)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model state (frame level)
    int m_mode;      // 0 waiting for frame, 1 writing lines, 2 frame finished
    int m_k;         // lines committed since frame start
    int m_trig;
    int m_ovr;
    int prev_x, prev_y;
    int line_wr;     // wren pulses observed on the current line

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    endtask

    task automatic model_reset();
        m_mode = 0; m_k = 0; m_trig = 0; m_ovr = 0;
        prev_x = 0; prev_y = 0;
    endtask

    // One clock of stimulus followed by the checks for that sample
    task automatic step(input int x, input int y);
        bit          e_wren;
        int          e_addr;
        logic [23:0] e_data;
        counterX = 12'(x);
        counterY = 12'(y);
        {red, green, blue} = 24'($urandom);
        e_wren = (m_mode == 1) && (x != prev_x) && (x < LW) && (y < LH);
        e_addr = (m_k % NL) * LW + x;
        e_data = {red, green, blue};
        if (resync && m_trig != 0) begin
            m_trig = 0;
            m_mode = 0;
        end else if (y != prev_y && y == 0) begin
            m_mode = 1;
            m_k    = 0;
        end else if (m_mode == 1 && m_k >= LH) begin
            m_mode = 2;
        end else if (m_mode == 1 && y != prev_y) begin
            if (OVR_EN && m_trig != 0 && ((m_k + 1) % NL) == int'(read_slot)) m_ovr = 1;
            m_k++;
            if (m_k == SL && !resync) m_trig = 1;
            $display("line commit: y=%0d lines=%0d slot=%0d trig=%0d ovr=%0d",
                     y, m_k, m_k % NL, m_trig, m_ovr);
        end
        if (resync) m_ovr = 0;
        prev_x = x;
        prev_y = y;
        @(posedge clock);
        #1;
        check_val("wren", 32'(wren), 32'(e_wren));
        if (wren) line_wr++;
        if (e_wren) begin
            check_val("wraddr", 32'(wraddr), 32'(e_addr));
            check_val("wrdata", 32'(wrdata), 32'(e_data));
        end
        check_val("write_slot", 32'(write_slot), 32'(m_k % NL));
        check_val("starttrigger", 32'(starttrigger), 32'(m_trig));
        check_val("overrun", 32'(overrun), 32'(m_ovr));
    endtask

    // One line: Y changes (optionally together with X), npix pixels at a
    // 2-cycle cadence, nbad out-of-range X values, then horizontal blanking
    task automatic do_line(input int y, input int npix, input int nbad, input bit simul);
        line_wr = 0;
        if (!simul) begin
            step(prev_x, y);
            step(prev_x, y);
        end
        for (int i = 0; i < npix; i++) begin
            step(i, y);
            step(i, y);
        end
        for (int j = 0; j < nbad; j++) begin
            int bx;
            bx = int'($urandom_range(LW, 1000));
            step(bx, y);
            step(bx, y);
        end
        step(HB, y);
        step(HB, y);
    endtask

    task automatic vblank();
        for (int i = 0; i < 3; i++) step(HB, VB);
    endtask

    task automatic rand_lines(input int y0, input int y1);
        for (int y = y0; y <= y1; y++)
            do_line(y, int'($urandom_range(4, 30)), int'($urandom_range(0, 4)),
                    (y != 0) && ($urandom_range(0, 1) == 1));
    endtask

    task automatic check_reset_outputs(input string tag);
        check_val({tag, "_wraddr"}, 32'(wraddr), 32'd0);
        check_val({tag, "_wrdata"}, 32'(wrdata), 32'd0);
        check_val({tag, "_wren"}, 32'(wren), 32'd0);
        check_val({tag, "_write_slot"}, 32'(write_slot), 32'd0);
        check_val({tag, "_starttrigger"}, 32'(starttrigger), 32'd0);
        check_val({tag, "_overrun"}, 32'(overrun), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        reset_n   = 1'b0;
        resync    = 1'b0;
        read_slot = 2'd2;
        counterX  = 12'(HB);
        counterY  = 12'(VB);
        {red, green, blue} = 24'd0;
        model_reset();
        repeat (3) @(posedge clock);
        #1;
        check_reset_outputs("reset");
        reset_n = 1'b1;

        // Frame A: five full lines (ring wrap), then random short lines
        vblank();
        for (int y = 0; y < 5; y++) begin
            do_line(y, LW, 0, 1'b0);
            check_val("line_wren_count", 32'(line_wr), 32'(LW));
        end
        rand_lines(5, 11);

        // Out-of-range line: nothing may be written
        do_line(LH, 20, 3, 1'b0);
        check_val("bounds_wren_count", 32'(line_wr), 32'd0);

        // Frame B, then a one-cycle resync re-arms the trigger
        vblank();
        rand_lines(0, 3);
        resync = 1'b1;
        step(prev_x, prev_y);
        resync = 1'b0;
        do_line(4, 10, 0, 1'b0);
        check_val("after_resync_wren_count", 32'(line_wr), 32'd0);

        // Frame C with resync held high: lines written, trigger stays low
        resync = 1'b1;
        vblank();
        rand_lines(0, 5);
        resync = 1'b0;

        // Frame D interrupted by reset in the middle of a line
        vblank();
        rand_lines(0, 2);
        read_slot = 2'($urandom_range(0, 3));
        for (int i = 0; i < 5; i++) begin
            step(i, 3);
            step(i, 3);
        end
        reset_n = 1'b0;
        #2;
        check_reset_outputs("async_reset");
        model_reset();
        @(posedge clock);
        #1;
        check_reset_outputs("held_reset");
        reset_n = 1'b1;
        line_wr = 0;
        for (int i = 5; i < 15; i++) begin
            step(i, 3);
            step(i, 3);
        end
        step(HB, 3);
        do_line(4, 12, 0, 1'b0);
        check_val("post_reset_wren_count", 32'(line_wr), 32'd0);

        // Frame E: writing resumes at the next frame start
        read_slot = 2'd2;
        vblank();
        rand_lines(0, 7);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
